comp_fetch_ctrl: RTL and testbench

//  Next-gen fetch controller between the core and two instruction caches: a full 32-bit icache and a

---
 rtl/comp_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_comp_fetch_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_fetch_ctrl.sv
// comp_fetch_ctrl: probes a compressed icache, decompresses via three dictionaries, else fetches and refills.
// Optional COMP_STATS_EN enables the hit/miss/fill counters; otherwise stat_* are tied to 0.
module comp_fetch_ctrl #(
  parameter  int K1_W = 3,
  parameter  int K2_W = 8,
  parameter  int K3_W = 5,
  localparam int CK_W = K1_W + K2_W + K3_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            proc_valid,
  input  logic [31:0]     proc_addr,
  output logic            proc_ready,
  output logic [31:0]     proc_rdata,
  output logic            cc_req_valid,
  output logic [31:0]     cc_req_addr,
  input  logic            cc_rsp_valid,
  input  logic            cc_rsp_hit,
  input  logic [CK_W-1:0] cc_rsp_key,
  output logic            cc_fill_valid,
  output logic [CK_W-1:0] cc_fill_key,
  output logic            ic_req_valid,
  output logic [31:0]     ic_req_addr,
  input  logic            ic_req_ready,
  input  logic [31:0]     ic_req_rdata,
  input  logic            dict1_we,
  input  logic [6:0]      dict1_wdata,
  output logic            dict1_full,
  input  logic            dict2_we,
  input  logic [14:0]     dict2_wdata,
  output logic            dict2_full,
  input  logic            dict3_we,
  input  logic [9:0]      dict3_wdata,
  output logic            dict3_full,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_misses,
  output logic [31:0]     stat_fills
);

  localparam int D1 = 1 << K1_W;
  localparam int D2 = 1 << K2_W;
  localparam int D3 = 1 << K3_W;

  typedef enum logic [2:0] {
    IDLE, CC_WAIT, DECOMP, IC_WAIT, LOOKUP, RESP
  } state_t;

  state_t          state, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     inst_q, inst_d;
  logic [CK_W-1:0] key_q, key_d;
  logic            cc_req_q, cc_req_d;

  logic [6:0]  d1 [D1];
  logic [14:0] d2 [D2];
  logic [9:0]  d3 [D3];
  logic [K1_W:0] cnt1;
  logic [K2_W:0] cnt2;
  logic [K3_W:0] cnt3;

  assign dict1_full = cnt1 == (K1_W+1)'(D1);
  assign dict2_full = cnt2 == (K2_W+1)'(D2);
  assign dict3_full = cnt3 == (K3_W+1)'(D3);

  // Entries past count are never read, so only the counts need reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt1 <= '0;
      cnt2 <= '0;
      cnt3 <= '0;
    end else begin
      if (dict1_we && !dict1_full) begin
        d1[cnt1[K1_W-1:0]] <= dict1_wdata;
        cnt1 <= cnt1 + (K1_W+1)'(1);
      end
      if (dict2_we && !dict2_full) begin
        d2[cnt2[K2_W-1:0]] <= dict2_wdata;
        cnt2 <= cnt2 + (K2_W+1)'(1);
      end
      if (dict3_we && !dict3_full) begin
        d3[cnt3[K3_W-1:0]] <= dict3_wdata;
        cnt3 <= cnt3 + (K3_W+1)'(1);
      end
    end
  end

  logic [K1_W-1:0] rk1;
  logic [K2_W-1:0] rk2;
  logic [K3_W-1:0] rk3;
  logic [6:0]      rv1;
  logic [14:0]     rv2;
  logic [9:0]      rv3;
  logic [31:0]     dec;

  assign rk1 = key_q[K1_W-1:0];
  assign rk2 = key_q[K1_W +: K2_W];
  assign rk3 = key_q[K1_W+K2_W +: K3_W];
  assign rv1 = ({1'b0, rk1} < cnt1) ? d1[rk1] : '0;
  assign rv2 = ({1'b0, rk2} < cnt2) ? d2[rk2] : '0;
  assign rv3 = ({1'b0, rk3} < cnt3) ? d3[rk3] : '0;
  assign dec = {rv3[9:3], rv2[14:5], rv3[2:0], rv2[4:0], rv1};

  logic [6:0]      f1;
  logic [14:0]     f2;
  logic [9:0]      f3;
  logic            m1, m2, m3;
  logic [K1_W-1:0] mk1;
  logic [K2_W-1:0] mk2;
  logic [K3_W-1:0] mk3;

  assign f1 = inst_q[6:0];
  assign f2 = {inst_q[24:15], inst_q[11:7]};
  assign f3 = {inst_q[31:25], inst_q[14:12]};

  // Scan high to low so the lowest matching index is the one kept.
  always_comb begin
    m1 = 1'b0;
    mk1 = '0;
    m2 = 1'b0;
    mk2 = '0;
    m3 = 1'b0;
    mk3 = '0;
    for (int i = D1 - 1; i >= 0; i--)
      if ((K1_W+1)'(i) < cnt1 && d1[i] == f1) begin
        m1 = 1'b1;
        mk1 = K1_W'(i);
      end
    for (int i = D2 - 1; i >= 0; i--)
      if ((K2_W+1)'(i) < cnt2 && d2[i] == f2) begin
        m2 = 1'b1;
        mk2 = K2_W'(i);
      end
    for (int i = D3 - 1; i >= 0; i--)
      if ((K3_W+1)'(i) < cnt3 && d3[i] == f3) begin
        m3 = 1'b1;
        mk3 = K3_W'(i);
      end
  end

  logic hit_ev, miss_ev, fill_ev;

  assign hit_ev  = (state == CC_WAIT) && cc_rsp_valid && cc_rsp_hit;
  assign miss_ev = (state == CC_WAIT) && cc_rsp_valid && !cc_rsp_hit;
  assign fill_ev = (state == LOOKUP) && m1 && m2 && m3;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      inst_q   <= '0;
      key_q    <= '0;
      cc_req_q <= 1'b0;
    end else begin
      state    <= state_d;
      addr_q   <= addr_d;
      inst_q   <= inst_d;
      key_q    <= key_d;
      cc_req_q <= cc_req_d;
    end
  end

  always_comb begin
    state_d  = state;
    addr_d   = addr_q;
    inst_d   = inst_q;
    key_d    = key_q;
    cc_req_d = 1'b0;
    unique case (state)
      IDLE:
        if (proc_valid) begin
          addr_d   = proc_addr;
          cc_req_d = 1'b1;
          state_d  = CC_WAIT;
        end
      CC_WAIT:
        if (hit_ev) begin
          key_d   = cc_rsp_key;
          state_d = DECOMP;
        end else if (miss_ev) begin
          state_d = IC_WAIT;
        end
      DECOMP: begin
        inst_d  = dec;
        state_d = RESP;
      end
      IC_WAIT:
        if (ic_req_ready) begin
          inst_d  = ic_req_rdata;
          state_d = LOOKUP;
        end
      LOOKUP:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cc_req_valid  = cc_req_q;
  assign cc_req_addr   = (cc_req_q || fill_ev) ? addr_q : '0;
  assign cc_fill_valid = fill_ev;
  assign cc_fill_key   = fill_ev ? {mk3, mk2, mk1} : '0;
  assign ic_req_valid  = state == IC_WAIT;
  assign ic_req_addr   = ic_req_valid ? addr_q : '0;
  assign proc_ready    = state == RESP;
  assign proc_rdata    = proc_ready ? inst_q : '0;

`ifdef COMP_STATS_EN
  logic [31:0] hits_q, misses_q, fills_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
      fills_q  <= '0;
    end else begin
      if (hit_ev)  hits_q   <= hits_q + 32'd1;
      if (miss_ev) misses_q <= misses_q + 32'd1;
      if (fill_ev) fills_q  <= fills_q + 32'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_fills  = fills_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
  assign stat_fills  = '0;
`endif

endmodule

// File: tb/tb_comp_fetch_ctrl.sv
// Randomized bench for comp_fetch_ctrl against a queue-based dictionary/cache model.
// Stats expectations follow COMP_STATS_EN when defined for the build.
module tb_comp_fetch_ctrl;
  localparam int K1_W = 3;
  localparam int K2_W = 8;
  localparam int K3_W = 5;
  localparam int CK_W = K1_W + K2_W + K3_W;
`ifdef COMP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            proc_valid;
  logic [31:0]     proc_addr;
  logic            proc_ready;
  logic [31:0]     proc_rdata;
  logic            cc_req_valid;
  logic [31:0]     cc_req_addr;
  logic            cc_rsp_valid;
  logic            cc_rsp_hit;
  logic [CK_W-1:0] cc_rsp_key;
  logic            cc_fill_valid;
  logic [CK_W-1:0] cc_fill_key;
  logic            ic_req_valid;
  logic [31:0]     ic_req_addr;
  logic            ic_req_ready;
  logic [31:0]     ic_req_rdata;
  logic            dict1_we, dict2_we, dict3_we;
  logic [6:0]      dict1_wdata;
  logic [14:0]     dict2_wdata;
  logic [9:0]      dict3_wdata;
  logic            dict1_full, dict2_full, dict3_full;
  logic [31:0]     stat_hits, stat_misses, stat_fills;

  always #5 clk = ~clk;

  comp_fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .proc_valid(proc_valid), .proc_addr(proc_addr),
    .proc_ready(proc_ready), .proc_rdata(proc_rdata),
    .cc_req_valid(cc_req_valid), .cc_req_addr(cc_req_addr),
    .cc_rsp_valid(cc_rsp_valid), .cc_rsp_hit(cc_rsp_hit),
    .cc_rsp_key(cc_rsp_key),
    .cc_fill_valid(cc_fill_valid), .cc_fill_key(cc_fill_key),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_req_ready(ic_req_ready), .ic_req_rdata(ic_req_rdata),
    .dict1_we(dict1_we), .dict1_wdata(dict1_wdata), .dict1_full(dict1_full),
    .dict2_we(dict2_we), .dict2_wdata(dict2_wdata), .dict2_full(dict2_full),
    .dict3_we(dict3_we), .dict3_wdata(dict3_wdata), .dict3_full(dict3_full),
    .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_fills(stat_fills)
  );

  int errors = 0;
  int checks = 0;
  int q1[$];
  int q2[$];
  int q3[$];
  logic [31:0] m_hits, m_misses, m_fills;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int mget(int n, int idx);
    case (n)
      1: return (idx < q1.size()) ? q1[idx] : 0;
      2: return (idx < q2.size()) ? q2[idx] : 0;
      default: return (idx < q3.size()) ? q3[idx] : 0;
    endcase
  endfunction

  function automatic int msize(int n);
    case (n)
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic int mfind(int n, int v);
    for (int i = 0; i < msize(n); i++)
      if (mget(n, i) == v) return i;
    return -1;
  endfunction

  function automatic logic [31:0] compose(int a, int b, int c);
    logic [31:0] r;
    logic [14:0] bb;
    logic [9:0]  cc;
    bb = b[14:0];
    cc = c[9:0];
    r = '0;
    r[6:0]   = a[6:0];
    r[11:7]  = bb[4:0];
    r[24:15] = bb[14:5];
    r[14:12] = cc[2:0];
    r[31:25] = cc[9:3];
    return r;
  endfunction

  task automatic model_clear;
    q1.delete();
    q2.delete();
    q3.delete();
    m_hits = 0;
    m_misses = 0;
    m_fills = 0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    proc_valid = 1'b0;
    cc_rsp_valid = 1'b0;
    ic_req_ready = 1'b0;
    step;
    step;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic dict_wr(input bit w1, input int v1, input bit w2, input int v2,
                         input bit w3, input int v3);
    dict1_we = w1;
    dict1_wdata = v1[6:0];
    dict2_we = w2;
    dict2_wdata = v2[14:0];
    dict3_we = w3;
    dict3_wdata = v3[9:0];
    step;
    dict1_we = 1'b0;
    dict2_we = 1'b0;
    dict3_we = 1'b0;
    if (w1 && q1.size() < 8)   q1.push_back(v1 & 'h7f);
    if (w2 && q2.size() < 256) q2.push_back(v2 & 'h7fff);
    if (w3 && q3.size() < 32)  q3.push_back(v3 & 'h3ff);
  endtask

  task automatic do_req(input string tag, input logic [31:0] addr, input bit hit,
                        input logic [CK_W-1:0] key, input logic [31:0] icd,
                        input int cd, input int icw, input bit drop);
    logic [31:0]     exp_d, got_d, faddr;
    logic [CK_W-1:0] exp_k, fkey;
    bit   done, exp_fill, leak, bad_ic_addr, bad_cc_addr;
    int   lat, exp_lat, ic_cyc, fills, probes, rsp_cnt, i1, i2, i3;
    int   k;
    k = int'(key);
    exp_k = '0;
    if (hit) begin
      exp_d = compose(mget(1, k & 7), mget(2, (k >> 3) & 255), mget(3, (k >> 11) & 31));
      exp_fill = 1'b0;
      exp_lat = 2 + cd + 1;
      m_hits++;
    end else begin
      exp_d = icd;
      i1 = mfind(1, int'(icd[6:0]));
      i2 = mfind(2, int'({icd[24:15], icd[11:7]}));
      i3 = mfind(3, int'({icd[31:25], icd[14:12]}));
      exp_fill = (i1 >= 0) && (i2 >= 0) && (i3 >= 0);
      if (exp_fill) exp_k = CK_W'((i3 << (K1_W + K2_W)) | (i2 << K1_W) | i1);
      exp_lat = 3 + cd + icw + 1;
      m_misses++;
      if (exp_fill) m_fills++;
    end
    proc_addr = addr;
    proc_valid = 1'b1;
    done = 0; leak = 0; bad_ic_addr = 0; bad_cc_addr = 0;
    lat = 0; ic_cyc = 0; fills = 0; probes = 0; rsp_cnt = 0;
    got_d = '0; fkey = '0; faddr = '0;
    while (!done && lat < 60) begin
      step;
      lat++;
      cc_rsp_valid = 1'b0;
      cc_rsp_hit = 1'b0;
      cc_rsp_key = '0;
      ic_req_ready = 1'b0;
      ic_req_rdata = '0;
      if (drop && lat == 2) proc_valid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          cc_rsp_valid = 1'b1;
          cc_rsp_hit = hit;
          cc_rsp_key = hit ? key : CK_W'($urandom);
        end
      end
      if (cc_req_valid) begin
        probes++;
        if (cc_req_addr !== addr) bad_cc_addr = 1;
        rsp_cnt = cd;
      end
      if (ic_req_valid) begin
        ic_cyc++;
        if (ic_req_addr !== addr) bad_ic_addr = 1;
        if (ic_cyc == icw + 1) begin
          ic_req_ready = 1'b1;
          ic_req_rdata = icd;
        end
      end
      if (cc_fill_valid) begin
        fills++;
        fkey = cc_fill_key;
        faddr = cc_req_addr;
      end
      if (proc_ready) begin
        got_d = proc_rdata;
        done = 1;
        proc_valid = 1'b0;
      end else if (proc_rdata !== 32'h0) begin
        leak = 1;
      end
    end
    proc_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: no proc_ready within %0d cycles", tag, lat);
    end
    checks++;
    if (got_d !== exp_d) begin
      errors++;
      $display("FAIL %s rdata: got %h expected %h", tag, got_d, exp_d);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
    end
    checks++;
    if (probes !== 1 || bad_cc_addr) begin
      errors++;
      $display("FAIL %s probe: got %0d probes badaddr=%0d expected 1 at %h",
               tag, probes, bad_cc_addr, addr);
    end
    checks++;
    if (ic_cyc !== (hit ? 0 : icw + 1) || bad_ic_addr) begin
      errors++;
      $display("FAIL %s icache: got %0d req cycles badaddr=%0d expected %0d",
               tag, ic_cyc, bad_ic_addr, hit ? 0 : icw + 1);
    end
    checks++;
    if (fills !== int'(exp_fill)) begin
      errors++;
      $display("FAIL %s fill count: got %0d expected %0d", tag, fills, exp_fill);
    end
    if (exp_fill) begin
      checks++;
      if (fkey !== exp_k || faddr !== addr) begin
        errors++;
        $display("FAIL %s fill: got key %h addr %h expected key %h addr %h",
                 tag, fkey, faddr, exp_k, addr);
      end
    end
    checks++;
    if (leak) begin
      errors++;
      $display("FAIL %s rdata outside ready: got nonzero expected 0", tag);
    end
    step;
    checks++;
    if (proc_ready !== 1'b0 || proc_rdata !== 32'h0) begin
      errors++;
      $display("FAIL %s ready pulse: got ready=%b rdata=%h expected 0/0",
               tag, proc_ready, proc_rdata);
    end
    checks++;
    if ({stat_hits, stat_misses, stat_fills} !==
        (STATS ? {m_hits, m_misses, m_fills} : 96'h0)) begin
      errors++;
      $display("FAIL %s stats: got %0d/%0d/%0d expected %0d/%0d/%0d", tag,
               stat_hits, stat_misses, stat_fills,
               STATS ? m_hits : 0, STATS ? m_misses : 0, STATS ? m_fills : 0);
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({proc_ready, proc_rdata, cc_req_valid, cc_req_addr, cc_fill_valid,
         cc_fill_key, ic_req_valid, ic_req_addr, dict1_full, dict2_full,
         dict3_full, stat_hits, stat_misses, stat_fills} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got nonzero expected all 0 (ready=%b ccreq=%b icreq=%b)",
               proc_ready, cc_req_valid, ic_req_valid);
    end
  endtask

  task automatic test_directed;
    dict_wr(1, 'h33, 1, 'h294A, 1, 'h000);
    do_req("miss_fill", 32'h100, 0, '0, 32'h00A50533, 1, 0, 0);
    do_req("hit_key0", 32'h100, 1, '0, 32'h0, 1, 0, 0);
    do_req("miss_nofill", 32'h104, 0, '0, 32'h00B50533, 1, 2, 1);
  endtask

  task automatic test_dict_full;
    int base;
    do_reset();
    base = $urandom_range(0, 127);
    for (int i = 0; i < 9; i++) begin
      dict_wr(1, base + i, i == 0, 'h1234, i == 0, 'h2A5);
      checks++;
      if (dict1_full !== (i >= 7)) begin
        errors++;
        $display("FAIL dict1_full after write %0d: got %b expected %b",
                 i + 1, dict1_full, i >= 7);
      end
    end
    do_req("full_ninth", 32'h200, 0, '0, compose(base + 8, 'h1234, 'h2A5), 1, 0, 0);
    do_req("full_eighth", 32'h204, 0, '0, compose(base + 7, 'h1234, 'h2A5), 2, 1, 0);
    do_req("full_hit7", 32'h208, 1, CK_W'(7), 32'h0, 1, 0, 0);
  endtask

  task automatic test_reset_mid;
    int n;
    dict_wr(0, 0, 0, 0, 0, 0);
    proc_addr = 32'h300;
    proc_valid = 1'b1;
    step;
    proc_valid = 1'b0;
    cc_rsp_valid = 1'b1;
    cc_rsp_hit = 1'b0;
    step;
    cc_rsp_valid = 1'b0;
    n = 0;
    while (!ic_req_valid && n < 10) begin
      step;
      n++;
    end
    checks++;
    if (ic_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid reach IC_WAIT: got ic_req_valid=%b expected 1", ic_req_valid);
    end
    reset = 1'b1;
    ic_req_ready = 1'b1;
    ic_req_rdata = 32'h00A50533;
    step;
    reset = 1'b0;
    ic_req_ready = 1'b0;
    model_clear();
    checks++;
    if ({proc_ready, proc_rdata, cc_req_valid, cc_fill_valid, ic_req_valid,
         dict1_full, stat_hits, stat_misses, stat_fills} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs: got ready=%b icreq=%b fill=%b expected 0",
               proc_ready, ic_req_valid, cc_fill_valid);
    end
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (proc_ready || cc_fill_valid) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL reset_mid abort: got %0d ready/fill cycles expected 0", n);
    end
    do_req("reset_mid_hit", 32'h100, 1, '0, 32'h0, 1, 0, 0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++)
      do_req("b2b", 32'h400 + 4 * i, i[0], CK_W'(i), 32'h12345678 + i, 1, 0, 0);
  endtask

  task automatic test_random;
    logic [31:0]     icd;
    logic [CK_W-1:0] key;
    int a, b, c;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      for (int w = 0; w < int'($urandom_range(0, 2)); w++)
        dict_wr($urandom_range(0, 1), $urandom_range(0, 127),
                $urandom_range(0, 1), $urandom_range(0, 15) * 1000,
                $urandom_range(0, 1), $urandom_range(0, 11) * 80);
      a = $urandom_range(0, 7);
      b = $urandom_range(0, 20);
      c = $urandom_range(0, 12);
      key = CK_W'((c << (K1_W + K2_W)) | (b << K1_W) | a);
      if ($urandom_range(0, 2) != 0)
        icd = compose(mget(1, $urandom_range(0, 8)), mget(2, $urandom_range(0, 20)),
                      mget(3, $urandom_range(0, 12)));
      else
        icd = $urandom;
      do_req("random", $urandom, $urandom_range(0, 1), key, icd,
             $urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 1));
    end
  endtask

  initial begin
    reset = 1'b1;
    proc_valid = 1'b0;
    proc_addr = '0;
    cc_rsp_valid = 1'b0;
    cc_rsp_hit = 1'b0;
    cc_rsp_key = '0;
    ic_req_ready = 1'b0;
    ic_req_rdata = '0;
    dict1_we = 1'b0;
    dict2_we = 1'b0;
    dict3_we = 1'b0;
    dict1_wdata = '0;
    dict2_wdata = '0;
    dict3_wdata = '0;
    model_clear();
    test_reset();
    test_directed();
    test_reset_mid();
    test_dict_full();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
